// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: branch funct3 codes and the branch-resolve FSM encoding.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned F3_W = 3;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        FLUSH    = 2'b10
    } bru_state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition from the ALU's rs1-rs2 flags; purely combinational.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [F3_W-1:0] funct3,
    input  logic            zero,
    input  logic            negative,
    input  logic            carry,
    input  logic            overflow,
    output logic            cond_c
);

    // Carry set means no borrow, i.e. rs1 >= rs2 unsigned; 010/011 never take.
    always_comb begin
        cond_c = 1'b0;
        case (funct3)
            F3_BEQ:  cond_c = zero;
            F3_BNE:  cond_c = ~zero;
            F3_BLT:  cond_c = negative ^ overflow;
            F3_BGE:  cond_c = ~(negative ^ overflow);
            F3_BLTU: cond_c = ~carry;
            F3_BGEU: cond_c = carry;
            default: cond_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: target generation, registered PC redirect,
// flush sequencing and resolved/taken performance counters.
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic [F3_W-1:0] ex_funct3,
    input  logic            ex_zero,
    input  logic            ex_negative,
    input  logic            ex_carry,
    input  logic            ex_overflow,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            misalign_err,
    output logic [XLEN-1:0] br_count,
    output logic [XLEN-1:0] taken_count
);

    localparam int unsigned CNT_W = 3;

    bru_state_e         state;
    logic [CNT_W-1:0]   flush_cnt;

    logic               cond_c;
    logic               resolve_c;
    logic               taken_c;
    logic               misalign_c;
    logic [XLEN-1:0]    target_c;

    branch_cond u_branch_cond (
        .funct3   (ex_funct3),
        .zero     (ex_zero),
        .negative (ex_negative),
        .carry    (ex_carry),
        .overflow (ex_overflow),
        .cond_c   (cond_c)
    );

    // Resolve decision and target; JALR outranks JAL, which outranks a branch.
    always_comb begin
        resolve_c  = ex_valid & (ex_branch | ex_jal | ex_jalr) & (state == IDLE);
        taken_c    = ex_jalr | ex_jal | (ex_branch & cond_c);
        if (ex_jalr) begin
            target_c = (ex_rs1 + ex_imm) & ~XLEN'(1);
        end else begin
            target_c = ex_pc + ex_imm;
        end
        misalign_c = target_c[1];
    end

    // Redirect/flush sequencer and counters; EX inputs are ignored outside IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            flush_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            misalign_err   <= 1'b0;
            br_count       <= '0;
            taken_count    <= '0;
        end else begin
            redirect_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (resolve_c) begin
                        br_count <= br_count + XLEN'(1);
                        if (taken_c) begin
                            taken_count <= taken_count + XLEN'(1);
                            if (misalign_c) begin
                                misalign_err <= 1'b1;
                            end else begin
                                state          <= REDIRECT;
                                redirect_valid <= 1'b1;
                                redirect_pc    <= target_c;
                                flush_if_id    <= 1'b1;
                                flush_id_ex    <= 1'b1;
                            end
                        end
                    end
                end
                REDIRECT: begin
                    if (FLUSH_CYCLES <= 1) begin
                        state       <= IDLE;
                        flush_if_id <= 1'b0;
                        flush_id_ex <= 1'b0;
                    end else begin
                        state     <= FLUSH;
                        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt <= CNT_W'(1)) begin
                        state       <= IDLE;
                        flush_if_id <= 1'b0;
                        flush_id_ex <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    flush_if_id <= 1'b0;
                    flush_id_ex <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit against an operand-level reference model.
module tb_branch_resolve_unit;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_branch, ex_jal, ex_jalr;
    logic [2:0]  ex_funct3;
    logic        ex_zero, ex_negative, ex_carry, ex_overflow;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id, flush_id_ex, misalign_err;
    logic [31:0] br_count, taken_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: operands behind the flags, and expected outputs.
    logic [31:0] m_a, m_b;
    int          m_busy;
    logic        m_rv;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_br, m_tk;

    always #5 clk = ~clk;

    branch_resolve_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_jal         (ex_jal),
        .ex_jalr        (ex_jalr),
        .ex_funct3      (ex_funct3),
        .ex_zero        (ex_zero),
        .ex_negative    (ex_negative),
        .ex_carry       (ex_carry),
        .ex_overflow    (ex_overflow),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .misalign_err   (misalign_err),
        .br_count       (br_count),
        .taken_count    (taken_count)
    );

    task automatic model_reset();
        m_busy = 0;
        m_rv   = 1'b0;
        m_pc   = 32'h0;
        m_mis  = 1'b0;
        m_br   = 32'h0;
        m_tk   = 32'h0;
    endtask

    // Decide the branch from the real operands, not from the flags.
    task automatic model_update();
        logic        cnd;
        logic        tk;
        logic [31:0] tgt;
        m_rv = 1'b0;
        if (m_busy == 0 && ex_valid && (ex_branch || ex_jal || ex_jalr)) begin
            case (ex_funct3)
                3'b000:  cnd = (m_a == m_b);
                3'b001:  cnd = (m_a != m_b);
                3'b100:  cnd = ($signed(m_a) < $signed(m_b));
                3'b101:  cnd = ($signed(m_a) >= $signed(m_b));
                3'b110:  cnd = (m_a < m_b);
                3'b111:  cnd = (m_a >= m_b);
                default: cnd = 1'b0;
            endcase
            tk  = ex_jal || ex_jalr || (ex_branch && cnd);
            tgt = ex_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
            m_br = m_br + 32'd1;
            if (tk) begin
                m_tk = m_tk + 32'd1;
                if (tgt[1]) begin
                    m_mis = 1'b1;
                end else begin
                    m_rv   = 1'b1;
                    m_pc   = tgt;
                    m_busy = FC;
                end
            end
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
        end
    endtask

    // Drive one EX-stage cycle at the falling edge, then settle after the rising edge.
    task automatic cycle_apply(input logic v, input logic br, input logic jal, input logic jalr,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
        logic [31:0] d;
        @(negedge clk);
        m_a = a;
        m_b = b;
        d   = a - b;
        ex_valid    = v;
        ex_branch   = br;
        ex_jal      = jal;
        ex_jalr     = jalr;
        ex_funct3   = f3;
        ex_zero     = (d == 32'h0);
        ex_negative = d[31];
        ex_carry    = (a >= b);
        ex_overflow = (a[31] != b[31]) && (d[31] != a[31]);
        ex_pc       = pc;
        ex_imm      = imm;
        ex_rs1      = rs1;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_apply(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
        ex_funct3 = 3'd0; ex_zero = 1'b0; ex_negative = 1'b0; ex_carry = 1'b0; ex_overflow = 1'b0;
        ex_pc = 32'h0; ex_imm = 32'h0; ex_rs1 = 32'h0;
        model_reset();
        #13;
        checks++;
        if ({redirect_valid, flush_if_id, flush_id_ex, misalign_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {redirect_valid, flush_if_id, flush_id_ex, misalign_err});
        end
        checks++;
        if ({redirect_pc, br_count, taken_count} !== 96'h0) begin
            errors++;
            $display("FAIL reset_regs got %h %h %h want 0", redirect_pc, br_count, taken_count);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        // BEQ taken: pc 0x100 + 0x20
        cycle_apply(1, 1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h100, 32'h20, 0);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin
            errors++; $display("FAIL beq_redirect got %b %h want 1 00000120", redirect_valid, redirect_pc);
        end
        checks++;
        if ({flush_if_id, flush_id_ex} !== 2'b11 || br_count !== 32'd1 || taken_count !== 32'd1) begin
            errors++; $display("FAIL beq_flush_cnt got %b %0d %0d want 11 1 1", {flush_if_id, flush_id_ex}, br_count, taken_count);
        end
        idle(1);
        checks++;
        if (redirect_valid !== 1'b0 || {flush_if_id, flush_id_ex} !== 2'b11) begin
            errors++; $display("FAIL beq_flush2 got %b %b want 0 11", redirect_valid, {flush_if_id, flush_id_ex});
        end
        idle(1);
        checks++;
        if ({flush_if_id, flush_id_ex} !== 2'b00) begin
            errors++; $display("FAIL beq_flush_end got %b want 00", {flush_if_id, flush_id_ex});
        end
        // BLTU with no borrow: not taken
        cycle_apply(1, 1, 0, 0, 3'b110, 32'd5, 32'd3, 32'h200, 32'h40, 0);
        checks++;
        if (redirect_valid !== 1'b0 || flush_if_id !== 1'b0 || br_count !== 32'd2 || taken_count !== 32'd1) begin
            errors++; $display("FAIL bltu_nt got %b %b %0d %0d want 0 0 2 1", redirect_valid, flush_if_id, br_count, taken_count);
        end
        cycle_apply(1, 1, 0, 0, 3'b111, 32'd5, 32'd3, 32'h200, 32'h40, 0);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h240) begin
            errors++; $display("FAIL bgeu_t got %b %h want 1 00000240", redirect_valid, redirect_pc);
        end
        idle(2);
        // BLT with N=0,V=1 (0x80000000 - 1)
        cycle_apply(1, 1, 0, 0, 3'b100, 32'h8000_0000, 32'd1, 32'h300, 32'hFFFF_FFF0, 0);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2F0) begin
            errors++; $display("FAIL blt_nv got %b %h want 1 000002f0", redirect_valid, redirect_pc);
        end
        idle(2);
        // BGE with N=1,V=1 (0x7fffffff - (-1))
        cycle_apply(1, 1, 0, 0, 3'b101, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h300, 32'h8, 0);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h308) begin
            errors++; $display("FAIL bge_nv got %b %h want 1 00000308", redirect_valid, redirect_pc);
        end
        idle(2);
        // BGE with N=1,V=0 (1 - 2): not taken
        cycle_apply(1, 1, 0, 0, 3'b101, 32'd1, 32'd2, 32'h300, 32'h8, 0);
        checks++;
        if (redirect_valid !== 1'b0 || br_count !== 32'd6 || taken_count !== 32'd4) begin
            errors++; $display("FAIL bge_nt got %b %0d %0d want 0 6 4", redirect_valid, br_count, taken_count);
        end
        // JALR to 0x2002: misaligned, counted, no redirect
        cycle_apply(1, 0, 0, 1, 3'b000, 0, 0, 32'h500, 32'h0, 32'h2003);
        checks++;
        if (redirect_valid !== 1'b0 || misalign_err !== 1'b1 || flush_if_id !== 1'b0 || taken_count !== 32'd5) begin
            errors++; $display("FAIL jalr_mis got %b %b %b %0d want 0 1 0 5", redirect_valid, misalign_err, flush_if_id, taken_count);
        end
        cycle_apply(1, 0, 0, 1, 3'b000, 0, 0, 32'h500, 32'h0, 32'h2001);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || misalign_err !== 1'b1) begin
            errors++; $display("FAIL jalr_ok got %b %h %b want 1 00002000 1", redirect_valid, redirect_pc, misalign_err);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] br0, tk0;
        br0 = br_count;
        tk0 = taken_count;
        cycle_apply(1, 0, 1, 0, 3'b000, 0, 0, 32'h400, 32'h10, 0);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h410 || br_count !== br0 + 32'd1) begin
            errors++; $display("FAIL b2b_jal got %b %h %0d want 1 00000410 %0d", redirect_valid, redirect_pc, br_count, br0 + 32'd1);
        end
        cycle_apply(1, 1, 0, 0, 3'b000, 32'd9, 32'd9, 32'h600, 32'h20, 0);
        checks++;
        if (redirect_valid !== 1'b0 || flush_id_ex !== 1'b1 || br_count !== br0 + 32'd1 || taken_count !== tk0 + 32'd1) begin
            errors++; $display("FAIL b2b_squash1 got %b %b %0d %0d", redirect_valid, flush_id_ex, br_count, taken_count);
        end
        cycle_apply(1, 1, 0, 0, 3'b000, 32'd9, 32'd9, 32'h600, 32'h20, 0);
        checks++;
        if (redirect_valid !== 1'b0 || flush_id_ex !== 1'b0 || br_count !== br0 + 32'd1) begin
            errors++; $display("FAIL b2b_squash2 got %b %b %0d", redirect_valid, flush_id_ex, br_count);
        end
        cycle_apply(1, 1, 0, 0, 3'b000, 32'd9, 32'd9, 32'h600, 32'h20, 0);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h620 || br_count !== br0 + 32'd2 || taken_count !== tk0 + 32'd2) begin
            errors++; $display("FAIL b2b_t3 got %b %h %0d %0d", redirect_valid, redirect_pc, br_count, taken_count);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_flush();
        cycle_apply(1, 0, 1, 0, 3'b000, 0, 0, 32'h800, 32'h40, 0);
        idle(1);
        checks++;
        if (flush_if_id !== 1'b1) begin
            errors++; $display("FAIL rst_pre got %b want 1", flush_if_id);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({flush_if_id, flush_id_ex, redirect_valid, misalign_err} !== 4'b0000 || br_count !== 32'h0 || taken_count !== 32'h0) begin
            errors++; $display("FAIL rst_mid got %b %0d %0d want 0000 0 0",
                               {flush_if_id, flush_id_ex, redirect_valid, misalign_err}, br_count, taken_count);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle_apply(1, 1, 0, 0, 3'b001, 32'd1, 32'd2, 32'h900, 32'h4, 0);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h904 || br_count !== 32'd1 || taken_count !== 32'd1) begin
            errors++; $display("FAIL rst_after got %b %h %0d %0d want 1 00000904 1 1", redirect_valid, redirect_pc, br_count, taken_count);
        end
        idle(2);
    endtask

    task automatic test_random();
        logic [2:0]  t;
        logic [31:0] a, b, pc, imm, rs1;
        for (int i = 0; i < 400; i++) begin
            t   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = $urandom;
            if ($urandom_range(0, 3) != 0) imm[1] = 1'b0;
            rs1 = $urandom;
            if ($urandom_range(0, 3) != 0) rs1[1] = imm[1];
            cycle_apply(($urandom_range(0, 4) != 0), t[0], t[1], t[2], 3'($urandom_range(0, 7)), a, b, pc, imm, rs1);
            checks++;
            if (redirect_valid !== m_rv || (m_rv && redirect_pc !== m_pc)) begin
                errors++; $display("FAIL rnd_redirect[%0d] got %b %h want %b %h", i, redirect_valid, redirect_pc, m_rv, m_pc);
            end
            checks++;
            if (flush_if_id !== (m_busy > 0) || flush_id_ex !== (m_busy > 0)) begin
                errors++; $display("FAIL rnd_flush[%0d] got %b%b want %b", i, flush_if_id, flush_id_ex, (m_busy > 0));
            end
            checks++;
            if (br_count !== m_br || taken_count !== m_tk || misalign_err !== m_mis) begin
                errors++; $display("FAIL rnd_count[%0d] got %0d %0d %b want %0d %0d %b",
                                   i, br_count, taken_count, misalign_err, m_br, m_tk, m_mis);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
